uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Parametrised UART receiver with 16x oversampling, majority-vote bit sampling and a show-ahead RX FIFO.
//  Data width, parity mode, stop-bit count, baud rate and FIFO depth are all parameters.
//  Sits between the board RX pin and the host register interface.
//  Per-frame parity and frame flags travel with the data; overrun and break are reported separately.
// PARAMETERS
//  CLK_HZ      24000000  clk24m frequency, Hz
//  BAUD        115200    line rate, bit/s
//  DATA_BITS   8         data bits per frame, 5..8, LSB first
//  PARITY      2         0 = none, 1 = even, 2 = odd
//  STOP_BITS   1         1 or 2
//  FIFO_DEPTH  4         entries, power of 2, >= 2
// PORTS
//  clk24m    in   1            system clock
//  rst       in   1            reset, synchronous, active-high
//  rx        in   1            asynchronous serial input, idle high
//  rd_en     in   1            pop head entry; ignored when dat_rdy = 0
//  err_clr   in   1            clears ovr_err
//  dat_o     out  DATA_BITS    head entry data, valid while dat_rdy = 1
//  dat_rdy   out  1            FIFO not empty
//  par_err   out  1            parity error flag of head entry (0 when PARITY = 0 or FIFO empty)
//  frm_err   out  1            stop-bit error flag of head entry (0 when FIFO empty)
//  ovr_err   out  1            sticky: a frame was dropped because the FIFO was full
//  brk_det   out  1            1-cycle pulse: break detected
//  fifo_cnt  out  clog2(D)+1   number of occupied entries
// BEHAVIOUR
//  Reset: all outputs 0, FIFO emptied, FSM = IDLE, both sync flops = 1. Applies mid-frame too.
//  rx is synchronised by 2 flops before any use.
//  Tick: DIV = round(CLK_HZ / (BAUD*16)) = 13 at the defaults.
//   - Counter runs 0..DIV-1 and asserts tick for 1 cycle at DIV-1.
//   - Elaboration error if DIV < 2.
//  FSM (advances only on tick; sample counter sc is 0..15):
//   - IDLE: synced rx = 0 -> START, sc = 0.
//   - START: sample rx at sc = 7, 8, 9; majority at sc = 9.
//     - Majority 1 -> IDLE (glitch rejected).
//     - Majority 0 -> DATA; sc continues, so every later decision lands at sc = 9 (mid-bit).
//   - DATA: DATA_BITS majority decisions, shifted in LSB first -> PAR if PARITY != 0, else STOP.
//   - PAR: parity check over data + parity bit.
//     - Even (1): total ones must be even; odd (2): total ones must be odd.
//   - STOP: STOP_BITS decisions; frm_err = 1 if any stop bit is 0.
//     - After the last decision: push the entry, go to IDLE at once (no wait for end of bit).
//  Push:
//   - One cycle after the last stop decision, write {data, par_err, frm_err} to the FIFO.
//   - dat_rdy rises on the following cycle.
//  Break: data = 0, parity bit (if used) = 0 and first stop bit = 0.
//   - brk_det pulses 1 cycle, coincident with the push.
//   - The frame is still pushed, with frm_err = 1.
//   - FSM then holds in IDLE until synced rx = 1 has been seen, so no false start follows.
//  FIFO (show-ahead):
//   - dat_o, par_err and frm_err reflect the head combinationally from storage.
//   - rd_en with dat_rdy = 1 pops; rd_en when empty has no effect.
//   - Full and a push arrives: the new frame is dropped, contents are unchanged, ovr_err = 1.
//   - Full with push and pop in the same cycle: both happen, no overrun, fifo_cnt unchanged.
//   - Pointers wrap modulo FIFO_DEPTH; fifo_cnt saturates at FIFO_DEPTH.
//  ovr_err: cleared by err_clr. If err_clr and a new overrun occur in the same cycle, set wins.
// TESTING (defaults: DIV = 13, bit period = 208 clk24m)
//  1. Send 0xA5, parity 1, stop 1 -> dat_rdy = 1, dat_o = 0xA5, par_err = 0, frm_err = 0, fifo_cnt = 1;
//     rd_en for 1 cycle -> dat_rdy = 0.
//  2. Send 0xA5 with parity 0 -> dat_o = 0xA5, par_err = 1.
//     Send 0x3C with stop bit 0 -> frm_err = 1 for that entry.
//  3. Low pulse of 39 clk on idle line -> no START accepted, fifo_cnt stays 0.
//     Hold rx low for 12 bit periods -> brk_det pulses once, entry 0x00 with frm_err = 1,
//     then exactly one further frame after rx returns high.
//  4. Send 0x01..0x05 back-to-back, no reads -> fifo_cnt = 4, ovr_err = 1;
//     pops return 0x01..0x04 in order; err_clr -> ovr_err = 0.
//  5. FIFO full, rd_en asserted in the push cycle of frame 5 -> no overrun, fifo_cnt = 4, 0x05 is last.
//  6. rst mid data bit 4 -> all outputs 0 next cycle; the next clean frame 0x5A is received correctly.
//     Repeat test 1 at BAUD +2% and -2% -> data correct.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver: 16x oversampling, 3-sample majority vote,
// parity/frame/break detection, show-ahead RX FIFO with overrun flag.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 24000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 2,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk24m,
  input  logic                         rst,
  input  logic                         rx,
  input  logic                         rd_en,
  input  logic                         err_clr,
  output logic [DATA_BITS-1:0]         dat_o,
  output logic                         dat_rdy,
  output logic                         par_err,
  output logic                         frm_err,
  output logic                         ovr_err,
  output logic                         brk_det,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_cnt
);

  localparam int DIV = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int DVW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EW  = DATA_BITS + 2;

  if (DIV < 2) begin : g_div_chk
    $error("uart_rx_fifo: baud divider below 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRKW
  } state_t;

  logic           r_sync1, r_sync2;
  logic [DVW-1:0] r_div;
  logic           w_tick, w_rxs, w_vote, w_bk;

  state_t         r_state, w_state_n;
  logic [3:0]     r_sc, w_sc_n;
  logic           r_s1, w_s1_n, r_s2, w_s2_n;
  logic [2:0]     r_bc, w_bc_n;
  logic [DATA_BITS-1:0] r_sh, w_sh_n;
  logic           r_pe, w_pe_n, r_fe, w_fe_n;
  logic           r_pbit, w_pbit_n;
  logic           r_sbc, w_sbc_n;
  logic           r_bk, w_bk_n;
  logic           r_push, w_push_n;
  logic           r_brk, w_brk_n;

  logic [EW-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wp, r_rp;
  logic [AW:0]    r_cnt;
  logic           r_ovr;
  logic           w_ne, w_full, w_pop, w_wr, w_ovr;
  logic [EW-1:0]  w_head;

  assign w_rxs  = r_sync2;
  assign w_tick = (r_div == DVW'(DIV - 1));
  assign w_vote = (r_s1 & r_s2) | (r_s1 & w_rxs) | (r_s2 & w_rxs);

  // two-flop synchroniser for the asynchronous rx pin
  always_ff @(posedge clk24m) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // 16x oversampling tick divider
  always_ff @(posedge clk24m) begin
    if (rst)         r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + DVW'(1);
  end

  // receiver state and datapath registers
  always_ff @(posedge clk24m) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sc    <= '0;
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_bc    <= '0;
      r_sh    <= '0;
      r_pe    <= 1'b0;
      r_fe    <= 1'b0;
      r_pbit  <= 1'b0;
      r_sbc   <= 1'b0;
      r_bk    <= 1'b0;
      r_push  <= 1'b0;
      r_brk   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_sc    <= w_sc_n;
      r_s1    <= w_s1_n;
      r_s2    <= w_s2_n;
      r_bc    <= w_bc_n;
      r_sh    <= w_sh_n;
      r_pe    <= w_pe_n;
      r_fe    <= w_fe_n;
      r_pbit  <= w_pbit_n;
      r_sbc   <= w_sbc_n;
      r_bk    <= w_bk_n;
      r_push  <= w_push_n;
      r_brk   <= w_brk_n;
    end
  end

  // break = all-zero data, zero parity bit and zero first stop bit
  assign w_bk = (r_sbc == 1'b0)
              ? ((r_sh == '0) && !r_pbit && !w_vote)
              : r_bk;

  // next-state: all decisions taken on the tick at sample 9
  always_comb begin
    w_state_n = r_state;
    w_sc_n    = r_sc;
    w_s1_n    = r_s1;
    w_s2_n    = r_s2;
    w_bc_n    = r_bc;
    w_sh_n    = r_sh;
    w_pe_n    = r_pe;
    w_fe_n    = r_fe;
    w_pbit_n  = r_pbit;
    w_sbc_n   = r_sbc;
    w_bk_n    = r_bk;
    w_push_n  = 1'b0;
    w_brk_n   = 1'b0;
    if (w_tick) begin
      if (r_state != S_IDLE && r_state != S_BRKW) begin
        w_sc_n = r_sc + 4'd1;
        if (r_sc == 4'd7) w_s1_n = w_rxs;
        if (r_sc == 4'd8) w_s2_n = w_rxs;
      end
      case (r_state)
        S_IDLE: begin
          if (!w_rxs) begin
            w_state_n = S_START;
            w_sc_n    = '0;
            w_bc_n    = '0;
            w_pe_n    = 1'b0;
            w_fe_n    = 1'b0;
            w_pbit_n  = 1'b0;
            w_sbc_n   = 1'b0;
            w_bk_n    = 1'b0;
          end
        end
        S_START: begin
          if (r_sc == 4'd9)
            w_state_n = w_vote ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          if (r_sc == 4'd9) begin
            w_sh_n = {w_vote, r_sh[DATA_BITS-1:1]};
            w_bc_n = r_bc + 3'd1;
            if (r_bc == 3'(DATA_BITS - 1))
              w_state_n = (PARITY != 0) ? S_PAR : S_STOP;
          end
        end
        S_PAR: begin
          if (r_sc == 4'd9) begin
            w_pbit_n  = w_vote;
            w_pe_n    = (PARITY == 1) ? (^r_sh ^ w_vote)
                                      : ~(^r_sh ^ w_vote);
            w_state_n = S_STOP;
          end
        end
        S_STOP: begin
          if (r_sc == 4'd9) begin
            if (!w_vote) w_fe_n = 1'b1;
            w_bk_n  = w_bk;
            w_sbc_n = r_sbc + 1'b1;
            if (r_sbc == 1'(STOP_BITS - 1)) begin
              w_push_n  = 1'b1;
              w_brk_n   = w_bk;
              w_state_n = w_bk ? S_BRKW : S_IDLE;
            end
          end
        end
        S_BRKW: begin
          if (w_rxs) w_state_n = S_IDLE;
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  assign w_ne   = (r_cnt != '0);
  assign w_full = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_pop  = rd_en & w_ne;
  assign w_wr   = r_push & (~w_full | w_pop);
  assign w_ovr  = r_push & w_full & ~w_pop;
  assign w_head = r_mem[r_rp];

  // FIFO storage: entry = {data, parity error, frame error}
  always_ff @(posedge clk24m) begin
    if (w_wr) r_mem[r_wp] <= {r_sh, r_pe, r_fe};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk24m) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr)  r_wp <= r_wp + AW'(1);
      if (w_pop) r_rp <= r_rp + AW'(1);
      if (w_wr && !w_pop)      r_cnt <= r_cnt + (AW+1)'(1);
      else if (!w_wr && w_pop) r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

  // sticky overrun; a new overrun beats a simultaneous clear
  always_ff @(posedge clk24m) begin
    if (rst)          r_ovr <= 1'b0;
    else if (w_ovr)   r_ovr <= 1'b1;
    else if (err_clr) r_ovr <= 1'b0;
  end

  assign dat_o    = w_ne ? w_head[EW-1:2] : '0;
  assign par_err  = w_ne & w_head[1];
  assign frm_err  = w_ne & w_head[0];
  assign dat_rdy  = w_ne;
  assign ovr_err  = r_ovr;
  assign brk_det  = r_brk;
  assign fifo_cnt = r_cnt;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo at default parameters
// (odd parity, 1 stop bit, depth 4, 208 clocks per bit).
module tb_uart_rx_fifo;

  localparam int BIT = 208;

  logic       clk24m = 1'b0;
  logic       rst, rx, rd_en, err_clr;
  logic [7:0] dat_o;
  logic       dat_rdy, par_err, frm_err, ovr_err, brk_det;
  logic [2:0] fifo_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int n_brk  = 0;

  uart_rx_fifo dut (
    .clk24m  (clk24m),
    .rst     (rst),
    .rx      (rx),
    .rd_en   (rd_en),
    .err_clr (err_clr),
    .dat_o   (dat_o),
    .dat_rdy (dat_rdy),
    .par_err (par_err),
    .frm_err (frm_err),
    .ovr_err (ovr_err),
    .brk_det (brk_det),
    .fifo_cnt(fifo_cnt)
  );

  always #5 clk24m = ~clk24m;

  always @(posedge clk24m) if (brk_det) n_brk <= n_brk + 1;

  task automatic bitx(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk24m);
  endtask

  task automatic send(input logic [7:0] d, input logic pgood,
                      input logic stp, input int bc);
    bitx(1'b0, bc);
    for (int i = 0; i < 8; i++) bitx(d[i], bc);
    bitx(pgood ? ~^d : ^d, bc);
    bitx(stp, bc);
    rx = 1'b1;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk24m);
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b1; rd_en = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk24m);
    rst = 1'b0;
    @(negedge clk24m);
    n_chk++;
    if (dat_rdy !== 1'b0) begin
      n_fail++; $display("FAIL reset_rdy: got %b want 0", dat_rdy);
    end
    n_chk++;
    if (fifo_cnt !== 3'd0) begin
      n_fail++; $display("FAIL reset_cnt: got %0d want 0", fifo_cnt);
    end
    n_chk++;
    if ({dat_o, par_err, frm_err, ovr_err, brk_det} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outs: got %h want 000",
               {dat_o, par_err, frm_err, ovr_err, brk_det});
    end
  endtask

  task automatic test_basic();
    send(8'hA5, 1'b1, 1'b1, BIT);
    bitx(1'b1, BIT);
    n_chk++;
    if (dat_rdy !== 1'b1) begin
      n_fail++; $display("FAIL basic_rdy: got %b want 1", dat_rdy);
    end
    n_chk++;
    if (dat_o !== 8'hA5) begin
      n_fail++; $display("FAIL basic_data: got %h want a5", dat_o);
    end
    n_chk++;
    if ({par_err, frm_err} !== 2'b00) begin
      n_fail++; $display("FAIL basic_flags: got %b want 00", {par_err, frm_err});
    end
    n_chk++;
    if (fifo_cnt !== 3'd1) begin
      n_fail++; $display("FAIL basic_cnt: got %0d want 1", fifo_cnt);
    end
    pop();
    n_chk++;
    if (dat_rdy !== 1'b0) begin
      n_fail++; $display("FAIL basic_pop: got %b want 0", dat_rdy);
    end
  endtask

  task automatic test_errors();
    send(8'hA5, 1'b0, 1'b1, BIT);
    bitx(1'b1, BIT);
    n_chk++;
    if ({dat_o, par_err, frm_err} !== {8'hA5, 2'b10}) begin
      n_fail++;
      $display("FAIL par_err: got %h/%b%b want a5/10", dat_o, par_err, frm_err);
    end
    pop();
    send(8'h3C, 1'b1, 1'b0, BIT);
    bitx(1'b1, BIT);
    n_chk++;
    if ({dat_o, par_err, frm_err} !== {8'h3C, 2'b01}) begin
      n_fail++;
      $display("FAIL frm_err: got %h/%b%b want 3c/01", dat_o, par_err, frm_err);
    end
    n_chk++;
    if (fifo_cnt !== 3'd1) begin
      n_fail++; $display("FAIL frm_cnt: got %0d want 1", fifo_cnt);
    end
    pop();
  endtask

  task automatic test_glitch_break();
    int nb0;
    bitx(1'b0, 39);
    bitx(1'b1, 3 * BIT);
    n_chk++;
    if (fifo_cnt !== 3'd0) begin
      n_fail++; $display("FAIL glitch_cnt: got %0d want 0", fifo_cnt);
    end
    nb0 = n_brk;
    bitx(1'b0, 12 * BIT);
    bitx(1'b1, 2 * BIT);
    n_chk++;
    if (n_brk - nb0 !== 1) begin
      n_fail++; $display("FAIL brk_pulses: got %0d want 1", n_brk - nb0);
    end
    n_chk++;
    if ({fifo_cnt, dat_o, frm_err} !== {3'd1, 8'h00, 1'b1}) begin
      n_fail++;
      $display("FAIL brk_entry: got cnt %0d %h/%b want 1 00/1",
               fifo_cnt, dat_o, frm_err);
    end
    send(8'h55, 1'b1, 1'b1, BIT);
    bitx(1'b1, BIT);
    n_chk++;
    if (fifo_cnt !== 3'd2) begin
      n_fail++; $display("FAIL brk_after_cnt: got %0d want 2", fifo_cnt);
    end
    pop();
    n_chk++;
    if ({dat_o, par_err, frm_err} !== {8'h55, 2'b00}) begin
      n_fail++;
      $display("FAIL brk_next: got %h/%b%b want 55/00", dat_o, par_err, frm_err);
    end
    pop();
    n_chk++;
    if (dat_rdy !== 1'b0) begin
      n_fail++; $display("FAIL brk_empty: got %b want 0", dat_rdy);
    end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b1, 1'b1, BIT);
    bitx(1'b1, BIT);
    n_chk++;
    if ({fifo_cnt, ovr_err} !== {3'd4, 1'b1}) begin
      n_fail++;
      $display("FAIL ovr_set: got cnt %0d ovr %b want 4 1", fifo_cnt, ovr_err);
    end
    for (int i = 1; i <= 4; i++) begin
      n_chk++;
      if (dat_o !== 8'(i)) begin
        n_fail++; $display("FAIL ovr_pop%0d: got %h want %h", i, dat_o, 8'(i));
      end
      pop();
    end
    n_chk++;
    if (dat_rdy !== 1'b0) begin
      n_fail++; $display("FAIL ovr_empty: got %b want 0", dat_rdy);
    end
    err_clr = 1'b1;
    @(negedge clk24m);
    err_clr = 1'b0;
    n_chk++;
    if (ovr_err !== 1'b0) begin
      n_fail++; $display("FAIL ovr_clr: got %b want 0", ovr_err);
    end
  endtask

  task automatic test_back_to_back();
    bit seen;
    seen = 1'b0;
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b1, 1'b1, BIT);
    n_chk++;
    if ({fifo_cnt, ovr_err} !== {3'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_full: got cnt %0d ovr %b want 4 0", fifo_cnt, ovr_err);
    end
    fork
      send(8'h05, 1'b1, 1'b1, BIT);
      begin
        for (int k = 0; k < 4000 && !seen; k++) begin
          @(negedge clk24m);
          if (dut.r_push) begin
            rd_en = 1'b1;
            @(negedge clk24m);
            rd_en = 1'b0;
            seen = 1'b1;
          end
        end
      end
    join
    n_chk++;
    if (seen !== 1'b1) begin
      n_fail++; $display("FAIL b2b_push_timeout: got 0 want 1");
    end
    bitx(1'b1, BIT);
    n_chk++;
    if ({fifo_cnt, ovr_err} !== {3'd4, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_same: got cnt %0d ovr %b want 4 0", fifo_cnt, ovr_err);
    end
    for (int i = 2; i <= 5; i++) begin
      n_chk++;
      if (dat_o !== 8'(i)) begin
        n_fail++; $display("FAIL b2b_pop%0d: got %h want %h", i, dat_o, 8'(i));
      end
      pop();
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'h5A;
    send(8'h11, 1'b1, 1'b1, BIT);
    bitx(1'b1, BIT);
    n_chk++;
    if (dat_rdy !== 1'b1) begin
      n_fail++; $display("FAIL rm_pre: got %b want 1", dat_rdy);
    end
    bitx(1'b0, BIT);
    for (int i = 0; i < 4; i++) bitx(d[i], BIT);
    bitx(d[4], BIT / 2);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk24m);
    rst = 1'b0;
    n_chk++;
    if ({dat_o, dat_rdy, par_err, frm_err, ovr_err, brk_det, fifo_cnt}
        !== 16'h0000) begin
      n_fail++;
      $display("FAIL rm_outs: got %h want 0000",
               {dat_o, dat_rdy, par_err, frm_err, ovr_err, brk_det, fifo_cnt});
    end
    bitx(1'b1, 4 * BIT);
    send(8'h5A, 1'b1, 1'b1, BIT);
    bitx(1'b1, BIT);
    n_chk++;
    if ({fifo_cnt, dat_o, par_err, frm_err} !== {3'd1, 8'h5A, 2'b00}) begin
      n_fail++;
      $display("FAIL rm_frame: got cnt %0d %h/%b%b want 1 5a/00",
               fifo_cnt, dat_o, par_err, frm_err);
    end
    pop();
  endtask

  task automatic test_baud();
    int bcs [2];
    bcs[0] = 212;
    bcs[1] = 204;
    for (int j = 0; j < 2; j++) begin
      send(8'hA5, 1'b1, 1'b1, bcs[j]);
      bitx(1'b1, bcs[j]);
      n_chk++;
      if ({fifo_cnt, dat_o, par_err, frm_err} !== {3'd1, 8'hA5, 2'b00}) begin
        n_fail++;
        $display("FAIL baud_%0d: got cnt %0d %h/%b%b want 1 a5/00",
                 bcs[j], fifo_cnt, dat_o, par_err, frm_err);
      end
      pop();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_glitch_break();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_baud();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
